// File: rtl/fir_src_pkg.sv
// Shared encodings and constants for the FIR stimulus source.
package fir_src_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_LFSR    = 2'd1,
        MODE_IMPULSE = 2'd2,
        MODE_ALT     = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] POS_MAX   = 8'h7F;
    localparam logic [7:0] NEG_MAX   = 8'h81;

endpackage

// File: rtl/fir_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) with seed reload and advance enable.
module fir_lfsr8
    import fir_src_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    output logic [7:0] q
);

    logic [7:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= LFSR_SEED;
        end else if (load) begin
            q_reg <= LFSR_SEED;
        end else if (enable) begin
            q_reg <= {q_reg[6:0], q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3]};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fir_sample_source.sv
// Burst stimulus generator driving the FIR din/vin stream: N samples with a
// programmable idle gap, selectable ramp/LFSR/impulse/alternating source.
module fir_sample_source
    import fir_src_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_samples,
    input  logic [GAP_W-1:0] gap,
    input  logic [1:0]       mode,
    output logic [7:0]       dout,
    output logic             vout,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] n_reg;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [GAP_W-1:0] gap_reg;
    mode_t            mode_reg;
    logic [7:0]       ramp_reg, ramp_next;
    logic [7:0]       lfsr_q;
    logic [7:0]       sample;
    logic             latch, lfsr_load, lfsr_en, last;

    fir_lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .q      (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            gap_cnt_reg <= '0;
            ramp_reg    <= '0;
            n_reg       <= '0;
            gap_reg     <= '0;
            mode_reg    <= MODE_RAMP;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            gap_cnt_reg <= gap_cnt_next;
            ramp_reg    <= ramp_next;
            if (latch) begin
                n_reg    <= n_samples;
                gap_reg  <= gap;
                mode_reg <= mode_t'(mode);
            end
        end
    end

    // count_reg holds the index of the sample being emitted, so compare to N-1
    // to reach 2^CNT_W-1 samples without wrapping.
    assign last = (count_reg == n_reg - CNT_W'(1));

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        gap_cnt_next = gap_cnt_reg;
        ramp_next    = ramp_reg;
        latch        = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_en      = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    latch      = 1'b1;
                    lfsr_load  = 1'b1;
                    ramp_next  = '0;
                    count_next = '0;
                    state_next = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                    ramp_next  = ramp_reg + 8'd1;
                    lfsr_en    = (mode_reg == MODE_LFSR);
                    if (last) begin
                        state_next = DONE;
                    end else if (gap_reg != '0) begin
                        state_next   = GAP;
                        gap_cnt_next = gap_reg - GAP_W'(1);
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample = ramp_reg;
        case (mode_reg)
            MODE_RAMP:    sample = ramp_reg;
            MODE_LFSR:    sample = lfsr_q;
            MODE_IMPULSE: sample = (count_reg == '0) ? POS_MAX : 8'h00;
            MODE_ALT:     sample = count_reg[0] ? NEG_MAX : POS_MAX;
            default:      sample = ramp_reg;
        endcase
    end

    assign vout = (state_reg == RUN);
    assign dout = vout ? sample : 8'h00;
    assign busy = (state_reg == RUN) || (state_reg == GAP);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_fir_sample_source.sv
// Directed and randomized bursts checked cycle-by-cycle against a
// sample-index/timing model of the stimulus source.
module tb_fir_sample_source;

    localparam int CNT_W = 12;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] n_samples = '0;
    logic [GAP_W-1:0] gap = '0;
    logic [1:0]       mode = '0;
    logic [7:0]       dout;
    logic             vout, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fir_sample_source #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .n_samples (n_samples),
        .gap       (gap),
        .mode      (mode),
        .dout      (dout),
        .vout      (vout),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input bit v, input logic [7:0] d,
                              input bit b, input bit dn);
        check({tag, ".vout"}, 32'(vout), 32'(v));
        check({tag, ".dout"}, 32'(dout), 32'(d));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Expected k-th sample of a burst, from the generator definitions.
    function automatic logic [7:0] model_sample(input int m, input int k, input logic [7:0] s);
        case (m)
            0:       return 8'(k % 256);
            1:       return s;
            2:       return (k == 0) ? 8'h7F : 8'h00;
            default: return (k % 2 == 0) ? 8'h7F : 8'h81;
        endcase
    endfunction

    // Runs one burst from IDLE/DONE. abort_at / spur_at are sample indices
    // (-1 disables); rst_at asserts reset in the first gap cycle after that sample.
    task automatic run_burst(input int m, input int nn, input int g, input int abort_at,
                             input int spur_at, input int rst_at, output bit ended_done);
        logic [7:0] s;
        int k;
        int total;
        bit is_samp;
        s = 8'h01;
        k = 0;
        ended_done = 1'b0;
        $display("burst mode=%0d n=%0d gap=%0d abort_at=%0d spur_at=%0d rst_at=%0d",
                 m, nn, g, abort_at, spur_at, rst_at);
        mode = 2'(m); n_samples = CNT_W'(nn); gap = GAP_W'(g); start = 1'b1;
        step();
        start = 1'b0;
        mode = 2'($urandom); n_samples = CNT_W'($urandom); gap = GAP_W'($urandom);
        total = (nn == 0) ? 0 : (nn - 1) * (g + 1) + 1;
        for (int c = 1; c <= total; c++) begin
            is_samp = ((c - 1) % (g + 1)) == 0;
            check_outs("burst", is_samp, is_samp ? model_sample(m, k, s) : 8'h00, 1'b1, 1'b0);
            if (is_samp && k == abort_at) begin
                abort = 1'b1;
                start = 1'($urandom_range(0, 1));
                step();
                abort = 1'b0;
                start = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    check_outs("abort", 1'b0, 8'h00, 1'b0, 1'b0);
                    step();
                end
                return;
            end
            if (!is_samp && rst_at >= 0 && k - 1 == rst_at) begin
                #2 rst = 1'b0;
                #1 check_outs("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);
                step();
                check_outs("in_rst", 1'b0, 8'h00, 1'b0, 1'b0);
                rst = 1'b1;
                step();
                return;
            end
            if (is_samp) begin
                if (k == spur_at) start = 1'b1;
                s = lfsr_next(s);
                k++;
            end
            step();
            start = 1'b0;
        end
        check_outs("end", 1'b0, 8'h00, 1'b0, 1'b1);
        ended_done = 1'b1;
    endtask

    initial begin
        bit fin;
        #12;
        check_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_outs("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        run_burst(0, 5, 0, -1, -1, -1, fin);
        run_burst(1, 6, 2, -1, -1, -1, fin);
        run_burst(1, 255, 0, -1, -1, -1, fin);
        run_burst(2, 4, 1, -1, -1, -1, fin);
        run_burst(3, 4, 0, -1, -1, -1, fin);
        run_burst(0, 0, 3, -1, -1, -1, fin);
        step();
        check_outs("zero_hold", 1'b0, 8'h00, 1'b0, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_outs("abort_in_done", 1'b0, 8'h00, 1'b0, 1'b1);
        run_burst(0, 300, 0, -1, 10, -1, fin);
        run_burst(0, 10, 1, 3, -1, -1, fin);
        run_burst(1, 6, 3, -1, -1, 2, fin);
        run_burst(1, 6, 1, -1, -1, -1, fin);
        run_burst(0, (1 << CNT_W) - 1, 0, -1, -1, -1, fin);

        for (int r = 0; r < 30; r++) begin
            int nn, g, ab, sp;
            nn = $urandom_range(0, 20);
            g  = $urandom_range(0, 5);
            ab = ($urandom_range(0, 3) == 0 && nn > 0) ? $urandom_range(0, nn - 1) : -1;
            sp = (nn > 1) ? $urandom_range(0, nn - 1) : -1;
            run_burst($urandom_range(0, 3), nn, g, ab, sp, -1, fin);
            repeat ($urandom_range(0, 3)) begin
                step();
                check_outs("between", 1'b0, 8'h00, 1'b0, fin);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
